// File: rtl/loader_pkg.sv
// Shared types and helpers for the instruction-image loader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_HI,
        ADDR_LO,
        CNT_HI,
        CNT_LO,
        DATA,
        START
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    function automatic int bytes_per_word(input int instr_w);
        return instr_w / 8;
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Byte-stream loader: parses a framed image, writes instruction memory word by word,
// then pulses start/start_address into fetch to launch the core.
module prog_loader
    import loader_pkg::*;
#(
    parameter int         INSTR_W   = 16,
    parameter int         ADDR_W    = 16,
    parameter int         START_CYC = 2,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               byte_valid_i,
    input  logic [7:0]         byte_i,
    output logic               byte_ready_o,
    output logic               imem_we_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    output logic [INSTR_W-1:0] imem_data_o,
    output logic               start_o,
    output logic [ADDR_W-1:0]  start_address_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam int BPW    = bytes_per_word(INSTR_W);
    localparam int BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int HOLD_W = $clog2(START_CYC + 1);

    state_t               r_state;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_we;
    logic                 r_start;
    logic [ADDR_W-1:0]    r_imem_addr;
    logic [INSTR_W-1:0]   r_imem_data;
    logic [ADDR_W-1:0]    r_start_addr;
    logic [7:0]           r_addr_hi;
    logic [ADDR_W-1:0]    r_base;
    logic [ADDR_W-1:0]    r_wptr;
    logic [7:0]           r_cnt_hi;
    logic [15:0]          r_count;
    logic [BIDX_W-1:0]    r_bidx;
    logic [INSTR_W-1:0]   r_word;
    logic [HOLD_W-1:0]    r_hold;

    logic                 w_xfer;
    logic [INSTR_W-1:0]   w_shift;
    logic [15:0]          w_cnt_full;
    logic                 w_last_byte;

    assign w_xfer      = byte_valid_i && r_ready;
    assign w_shift     = (r_word << 8) | INSTR_W'(byte_i);
    assign w_cnt_full  = {r_cnt_hi, byte_i};
    assign w_last_byte = (r_bidx == BIDX_W'(BPW - 1));

    // Outputs are all registered; ready/busy are updated alongside each state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_ready      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_we         <= 1'b0;
            r_start      <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_data  <= '0;
            r_start_addr <= '0;
            r_addr_hi    <= '0;
            r_base       <= '0;
            r_wptr       <= '0;
            r_cnt_hi     <= '0;
            r_count      <= '0;
            r_bidx       <= '0;
            r_word       <= '0;
            r_hold       <= '0;
        end else begin
            r_we <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_ready <= 1'b1;
                    if (w_xfer && byte_i == SYNC_BYTE) begin
                        r_state <= ADDR_HI;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                ADDR_HI: begin
                    if (w_xfer) begin
                        r_addr_hi <= byte_i;
                        r_state   <= ADDR_LO;
                    end
                end
                ADDR_LO: begin
                    if (w_xfer) begin
                        r_base  <= ADDR_W'({r_addr_hi, byte_i});
                        r_state <= CNT_HI;
                    end
                end
                CNT_HI: begin
                    if (w_xfer) begin
                        r_cnt_hi <= byte_i;
                        r_state  <= CNT_LO;
                    end
                end
                CNT_LO: begin
                    if (w_xfer) begin
                        r_count <= w_cnt_full;
                        r_wptr  <= r_base;
                        r_bidx  <= '0;
                        if (w_cnt_full == 16'd0) begin
                            r_state      <= START;
                            r_ready      <= 1'b0;
                            r_hold       <= '0;
                            r_start_addr <= r_base;
                        end else begin
                            r_state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_xfer) begin
                        r_word <= w_shift;
                        if (w_last_byte) begin
                            r_bidx      <= '0;
                            r_we        <= 1'b1;
                            r_imem_addr <= r_wptr;
                            r_imem_data <= w_shift;
                            r_wptr      <= r_wptr + ADDR_W'(1);
                            r_count     <= r_count - 16'd1;
                            // The final write pulse coincides with the first START cycle.
                            if (r_count == 16'd1) begin
                                r_state      <= START;
                                r_ready      <= 1'b0;
                                r_hold       <= '0;
                                r_start_addr <= r_base;
                            end
                        end else begin
                            r_bidx <= r_bidx + BIDX_W'(1);
                        end
                    end
                end
                START: begin
                    if (r_hold < HOLD_W'(START_CYC)) begin
                        r_start <= 1'b1;
                        r_hold  <= r_hold + HOLD_W'(1);
                    end else begin
                        r_start <= 1'b0;
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign byte_ready_o    = r_ready;
    assign imem_we_o       = r_we;
    assign imem_addr_o     = r_imem_addr;
    assign imem_data_o     = r_imem_data;
    assign start_o         = r_start;
    assign start_address_o = r_start_addr;
    assign busy_o          = r_busy;
    assign done_o          = r_done;

endmodule
